// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the dm_ctrl load/store controller: size codes, FSM states
// and the alignment rule used when DM_CTRL_MISALIGN_CHK_EN is defined.
package dm_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } state_t;

   // The illegal size code counts as misaligned so it takes the same error path.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return addr_lo != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane handling for dm_ctrl: extracts and extends load lanes,
// and merges sub-word store data into the containing word.
module dm_lane_align
   import dm_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] word_in,
   input  logic [15:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word_in[7:0];
      case (offset)
         2'd1:    byte_lane = word_in[15:8];
         2'd2:    byte_lane = word_in[23:16];
         2'd3:    byte_lane = word_in[31:24];
         default: byte_lane = word_in[7:0];
      endcase
      half_lane = offset[1] ? word_in[31:16] : word_in[15:0];

      case (size)
         SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
         default: load_data = word_in;
      endcase
   end

   // Only the addressed lane changes; the rest of the word comes from the read.
   always_comb begin
      merged = word_in;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd1:    merged[15:8]  = store_data[7:0];
               2'd2:    merged[23:16] = store_data[7:0];
               2'd3:    merged[31:24] = store_data[7:0];
               default: merged[7:0]   = store_data[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) merged[31:16] = store_data;
            else           merged[15:0]  = store_data;
         end
         default: merged = word_in;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Load/store controller in front of dm_4k; sub-word stores are read-modify-write.
// Define DM_CTRL_MISALIGN_CHK_EN to report misaligned/illegal-size requests via rsp_err.
module dm_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DM_WORDS = 1024
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [31:0]       dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   input  logic [31:0]       dm_dout
);

   localparam int IDX_W = $clog2(DM_WORDS);

   state_t           state, next_state;
   logic [IDX_W-1:0] idx_q;
   logic [1:0]       size_q, off_q;
   logic             we_q, unsigned_q, err_q;
   logic [15:0]      wdata_q;
   logic [31:0]      rdata_q, din_q;
   logic [1:0]       eff_size, eff_off;
   logic             req_err, accept;
   logic [31:0]      load_data, merged;
   logic             unused_addr_bits;

   assign accept           = req_valid && (state == ST_IDLE);
   assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W+2];

   // Without the checker, bad requests are coerced into legal aligned ones instead.
   always_comb begin
      eff_size = req_size;
      eff_off  = req_addr[1:0];
      req_err  = 1'b0;
`ifdef DM_CTRL_MISALIGN_CHK_EN
      req_err  = is_misaligned(req_size, req_addr[1:0]);
`else
      if (req_size == SZ_ILL) eff_size = SZ_WORD;
      case (eff_size)
         SZ_HALF: eff_off = {req_addr[1], 1'b0};
         SZ_WORD: eff_off = 2'b00;
         default: eff_off = req_addr[1:0];
      endcase
`endif
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_err)                             next_state = ST_RESP;
               else if (req_we && eff_size == SZ_WORD) next_state = ST_WR;
               else                                     next_state = ST_RD;
            end
         end
         ST_RD:   next_state = we_q ? ST_WR : ST_RESP;
         ST_WR:   next_state = ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   dm_lane_align u_lane_align (
      .size        (size_q),
      .offset      (off_q),
      .is_unsigned (unsigned_q),
      .word_in     (dm_dout),
      .store_data  (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Response data is cleared on accept so stores and errors report zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         size_q     <= SZ_BYTE;
         off_q      <= 2'b00;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         din_q      <= '0;
      end else if (accept) begin
         idx_q      <= req_addr[IDX_W+1:2];
         size_q     <= eff_size;
         off_q      <= eff_off;
         we_q       <= req_we;
         unsigned_q <= req_unsigned;
         err_q      <= req_err;
         wdata_q    <= req_wdata[15:0];
         rdata_q    <= '0;
         if (req_we && eff_size == SZ_WORD && !req_err) din_q <= req_wdata;
      end else if (state == ST_RD) begin
         if (we_q) din_q   <= merged;
         else      rdata_q <= load_data;
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign dm_we     = (state == ST_WR);
   assign dm_addr   = {{(32-IDX_W){1'b0}}, idx_q};
   assign dm_din    = din_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl with a word-array dm_4k stand-in and a byte-level
// reference model; expectations follow DM_CTRL_MISALIGN_CHK_EN when it is defined.
module tb_dm_ctrl;
   import dm_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, dm_we;
   logic [31:0] rsp_rdata, dm_addr, dm_din, dm_dout;

   logic [31:0] dm_mem [0:1023];
   logic [7:0]  ref_b  [0:4095];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_ctrl #(.ADDR_W(32), .DM_WORDS(1024)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .dm_addr      (dm_addr),
      .dm_din       (dm_din),
      .dm_we        (dm_we),
      .dm_dout      (dm_dout)
   );

   // Word-organised data memory: combinational read, write on the rising edge.
   assign dm_dout = dm_mem[dm_addr[9:0]];
   always @(posedge clk) if (dm_we) dm_mem[dm_addr[9:0]] <= dm_din;

   // Reference: byte-addressed memory updated by request semantics, not by FSM steps.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata, output int lat,
                        output logic wr, output logic [31:0] word, output int widx);
      int n;
      int a;
      logic [31:0] v;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      a = int'(addr[11:0]);
`ifdef DM_CTRL_MISALIGN_CHK_EN
      err = (size == 2'd3) || (a % n != 0);
`else
      err = 1'b0;
      a   = a - (a % n);
`endif
      widx  = a / 4;
      rdata = '0;
      wr    = 1'b0;
      lat   = 1;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++) ref_b[a+i] = wdata[8*i +: 8];
            wr  = 1'b1;
            lat = (n == 4) ? 2 : 3;
         end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[a+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rdata = v;
            lat   = 2;
         end
      end
      word = {ref_b[4*widx+3], ref_b[4*widx+2], ref_b[4*widx+1], ref_b[4*widx]};
   endtask

   // Issues one request from a negedge in IDLE and checks the whole transaction.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                         output logic [31:0] got_rdata, output logic got_err);
      logic        e_err, e_wr, busy_bad, din_bad;
      logic [31:0] e_rdata, e_word;
      int          e_lat, e_idx, cyc, we_cnt;
      model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_wr, e_word, e_idx);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid    = hold;
      req_we       = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = $urandom;
      req_wdata    = $urandom;
      cyc = 0; we_cnt = 0; busy_bad = 1'b0; din_bad = 1'b0;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) break;
         if (req_ready) busy_bad = 1'b1;
         if (dm_we) begin
            we_cnt++;
            if (dm_din !== e_word || dm_addr !== 32'(e_idx)) din_bad = 1'b1;
         end
      end
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      checks++;
      if (rsp_valid !== 1'b1 || cyc != e_lat) begin
         errors++;
         $display("[TB] FAIL latency addr=%h got=%0d valid=%b want=%0d", addr, cyc, rsp_valid, e_lat);
      end
      checks++;
      if (rsp_err !== e_err) begin
         errors++;
         $display("[TB] FAIL rsp_err addr=%h got=%b want=%b", addr, rsp_err, e_err);
      end
      checks++;
      if (rsp_rdata !== e_rdata) begin
         errors++;
         $display("[TB] FAIL rsp_rdata addr=%h got=%h want=%h", addr, rsp_rdata, e_rdata);
      end
      checks++;
      if (busy_bad || req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ready_busy addr=%h got=%b want=0", addr, busy_bad | req_ready);
      end
      checks++;
      if (we_cnt != (e_wr ? 1 : 0) || din_bad) begin
         errors++;
         $display("[TB] FAIL dm_write addr=%h we_cycles=%0d want=%0d din_bad=%b want_word=%h",
                  addr, we_cnt, e_wr ? 1 : 0, din_bad, e_word);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL after_resp got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
      end
      checks++;
      if (dm_mem[e_idx] !== e_word) begin
         errors++;
         $display("[TB] FAIL mem_word idx=%0d got=%h want=%h", e_idx, dm_mem[e_idx], e_word);
      end
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, dm_we} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got ready/valid/err/we=%b want=1000",
                  {req_ready, rsp_valid, rsp_err, dm_we});
      end
      checks++;
      if (rsp_rdata !== 32'h0 || dm_addr !== 32'h0 || dm_din !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got rdata=%h addr=%h din=%h want 0", rsp_rdata, dm_addr, dm_din);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] r, exp_w;
      logic        e, exp_e;
      do_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hAAAA_AAAA, 1'b0, r, e);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, r, e);
      checks++;
      if (r !== 32'hAAAA_AAAA) begin
         errors++;
         $display("[TB] FAIL lw_0 got=%h want=aaaaaaaa", r);
      end
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h1, 32'h0000_0055, 1'b0, r, e);
      checks++;
      if (dm_mem[0] !== 32'hAAAA_55AA) begin
         errors++;
         $display("[TB] FAIL sb_merge got=%h want=aaaa55aa", dm_mem[0]);
      end
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h1, 32'h0, 1'b0, r, e);
      checks++;
      if (r !== 32'h0000_0055) begin
         errors++;
         $display("[TB] FAIL lbu_1 got=%h want=00000055", r);
      end
      do_req(1'b0, SZ_HALF, 1'b0, 32'h2, 32'h0, 1'b0, r, e);
      checks++;
      if (r !== 32'hFFFF_AAAA) begin
         errors++;
         $display("[TB] FAIL lh_2 got=%h want=ffffaaaa", r);
      end
      do_req(1'b0, SZ_HALF, 1'b1, 32'h2, 32'h0, 1'b0, r, e);
      checks++;
      if (r !== 32'h0000_AAAA) begin
         errors++;
         $display("[TB] FAIL lhu_2 got=%h want=0000aaaa", r);
      end
`ifdef DM_CTRL_MISALIGN_CHK_EN
      exp_e = 1'b1; exp_w = 32'h0;
`else
      exp_e = 1'b0; exp_w = 32'h1234_5678;
`endif
      do_req(1'b1, SZ_WORD, 1'b0, 32'h6, 32'h1234_5678, 1'b0, r, e);
      checks++;
      if (e !== exp_e || dm_mem[1] !== exp_w) begin
         errors++;
         $display("[TB] FAIL sw_6 got err=%b word=%h want err=%b word=%h", e, dm_mem[1], exp_e, exp_w);
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic        e;
      for (int i = 0; i < 150; i++)
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)), $urandom, 1'b0, r, e);
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic        e;
      for (int i = 0; i < 20; i++)
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 31)), $urandom, (i != 19), r, e);
   endtask

   task automatic test_reset_in_wr();
      logic [31:0] old_word, r;
      logic        e, seen_we, seen_rsp;
      old_word = dm_mem[2];
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
      req_addr = 32'h9; req_wdata = ~{4{old_word[15:8]}};
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen_we = 1'b0;
      for (int i = 0; i < 6 && !seen_we; i++) begin
         @(negedge clk);
         seen_we = dm_we;
      end
      checks++;
      if (!seen_we) begin
         errors++;
         $display("[TB] FAIL wr_reach got dm_we=0 want=1");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dm_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_we got=%b want=0", dm_we);
      end
      seen_rsp = 1'b0;
      @(negedge clk);
      seen_rsp = seen_rsp | rsp_valid;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seen_rsp = seen_rsp | rsp_valid;
      end
      checks++;
      if (seen_rsp || req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_abort got rsp_seen=%b ready=%b want rsp_seen=0 ready=1", seen_rsp, req_ready);
      end
      checks++;
      if (dm_mem[2] !== old_word) begin
         errors++;
         $display("[TB] FAIL kept_word got=%h want=%h", dm_mem[2], old_word);
      end
      do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0, r, e);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) dm_mem[i] = '0;
      for (int i = 0; i < 4096; i++) ref_b[i] = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_in_wr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
